fire_ctrl: RTL

//  Per-tank fire scheduler sitting between player input and the bullet engine.

---
 rtl/fire_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/fire_ctrl.sv
// Per-tank fire scheduler: turns a fire button into single-cycle fire pulses,
// gated by free bullet slots, a post-shot cooldown and a reloading magazine.
module fire_ctrl #(
    parameter int unsigned MAX_BULLETS   = 8,
    parameter int unsigned COOLDOWN      = 16,
    parameter int unsigned AMMO          = 5,
    parameter int unsigned RELOAD_CYCLES = 256,
    parameter int unsigned TANK_SIZE     = 32,
    parameter int unsigned BULLET_SIZE   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   game_over,
    input  logic                   fire_btn,
    input  logic [9:0]             tank_x,
    input  logic [9:0]             tank_y,
    input  logic [1:0]             tank_dir,
    input  logic [MAX_BULLETS-1:0] bullet_active,
    output logic                   fire,
    output logic [1:0]             bullet_dir,
    output logic [9:0]             init_x,
    output logic [9:0]             init_y,
    output logic [3:0]             ammo_cnt,
    output logic                   reloading
);

    localparam int unsigned CNT_MAX = (COOLDOWN > RELOAD_CYCLES) ? COOLDOWN : RELOAD_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam int unsigned OFFSET  = (TANK_SIZE - BULLET_SIZE) / 2;

    typedef enum logic [1:0] {
        ST_READY  = 2'd0,
        ST_COOL   = 2'd1,
        ST_RELOAD = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic            fire_btn_q;
    logic            pending, pending_nxt;
    logic [1:0]      dir_q, dir_nxt;
    logic [CW-1:0]   cool_cnt, cool_nxt;
    logic [CW-1:0]   rel_cnt, rel_nxt;
    logic            fire_nxt;
    logic [1:0]      bullet_dir_nxt;
    logic [9:0]      init_x_nxt, init_y_nxt;
    logic [3:0]      ammo_nxt;
    logic            reloading_nxt;

    logic            press_c;
    logic            request_c;
    logic            can_shoot_c;
    logic            issue_c;

    // Registers: state, request tracking, counters and all outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_READY;
            fire_btn_q <= 1'b0;
            pending    <= 1'b0;
            dir_q      <= 2'd0;
            cool_cnt   <= '0;
            rel_cnt    <= '0;
            fire       <= 1'b0;
            bullet_dir <= 2'd0;
            init_x     <= 10'd0;
            init_y     <= 10'd0;
            ammo_cnt   <= 4'(AMMO);
            reloading  <= 1'b0;
        end else begin
            state      <= state_nxt;
            fire_btn_q <= fire_btn;
            pending    <= pending_nxt;
            dir_q      <= dir_nxt;
            cool_cnt   <= cool_nxt;
            rel_cnt    <= rel_nxt;
            fire       <= fire_nxt;
            bullet_dir <= bullet_dir_nxt;
            init_x     <= init_x_nxt;
            init_y     <= init_y_nxt;
            ammo_cnt   <= ammo_nxt;
            reloading  <= reloading_nxt;
        end
    end

    // Next-state: issue decision, pending flag, countdowns and output staging
    always_comb begin
        state_nxt      = state;
        pending_nxt    = pending;
        dir_nxt        = dir_q;
        cool_nxt       = cool_cnt;
        rel_nxt        = rel_cnt;
        fire_nxt       = 1'b0;
        bullet_dir_nxt = bullet_dir;
        init_x_nxt     = init_x;
        init_y_nxt     = init_y;
        ammo_nxt       = ammo_cnt;

        // A fresh press may issue in its own cycle so the pulse lands one cycle later.
        press_c     = fire_btn & ~fire_btn_q;
        request_c   = pending | press_c;
        // Cooldown reaching zero counts as ready, keeping the fire-to-fire gap at COOLDOWN.
        can_shoot_c = (state == ST_READY) || ((state == ST_COOL) && (cool_cnt == '0));
        issue_c     = request_c & can_shoot_c & ~game_over & ~(&bullet_active)
                      & (ammo_cnt != 4'd0) & ~fire;

        if (game_over) begin
            pending_nxt = 1'b0;
        end else if (issue_c) begin
            pending_nxt = 1'b0;
        end else if (press_c && !pending) begin
            pending_nxt = 1'b1;
            dir_nxt     = tank_dir;
        end

        case (state)
            ST_COOL: begin
                if (cool_cnt == '0) begin
                    state_nxt = ST_READY;
                end else begin
                    cool_nxt = cool_cnt - CW'(1);
                end
            end
            ST_RELOAD: begin
                if (rel_cnt == '0) begin
                    state_nxt = ST_READY;
                    ammo_nxt  = 4'(AMMO);
                end else begin
                    rel_nxt = rel_cnt - CW'(1);
                end
            end
            default: begin
                state_nxt = state;
            end
        endcase

        if (issue_c) begin
            fire_nxt       = 1'b1;
            bullet_dir_nxt = pending ? dir_q : tank_dir;
            init_x_nxt     = tank_x + 10'(OFFSET);
            init_y_nxt     = tank_y + 10'(OFFSET);
            ammo_nxt       = ammo_cnt - 4'd1;
            if (ammo_cnt == 4'd1) begin
                state_nxt = ST_RELOAD;
                rel_nxt   = CW'(RELOAD_CYCLES - 1);
            end else begin
                state_nxt = ST_COOL;
                cool_nxt  = CW'(COOLDOWN - 1);
            end
        end

        reloading_nxt = (state_nxt == ST_RELOAD);
    end

endmodule
